benes_cfg_ctrl: RTL

Configuration and flow controller for the `benes` permutation network (SIZE=32, DWIDTH=16, 9 stages × 16 switches = 144 control bits).

- Loads a new permutation one stage at a time into a shadow register.
- Tracks data beats in flight through the network's LAT-deep registered data path.
- Swaps shadow→active `control_bit` only when the data path is empty, so no beat ever sees a mixed configuration.
- Sits between the permutation-programming agent (scheduler/CPU side) and the `benes` + `xbar_if` datapath.

---
 rtl/benes_pkg.sv | 32 +++
 rtl/benes_vld_pipe.sv | 44 ++++
 rtl/benes_cfg_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/benes_pkg.sv
// Shared definitions for the benes permutation network and its configuration controller.
// Provides the size derivation helpers and the controller state type.
//   benes_tagwidth(size) : address bits per port
//   benes_stages(size)   : switch stages (2*log2(size)-1)
//   benes_sww(size)      : switches per stage (size/2)
//   benes_bitwidth(size) : total control bits (stages*switches)
package benes_pkg;

    function automatic int unsigned benes_tagwidth(input int unsigned size);
        return $clog2(size);
    endfunction

    function automatic int unsigned benes_stages(input int unsigned size);
        return 2 * $clog2(size) - 1;
    endfunction

    function automatic int unsigned benes_sww(input int unsigned size);
        return size / 2;
    endfunction

    function automatic int unsigned benes_bitwidth(input int unsigned size);
        return benes_stages(size) * benes_sww(size);
    endfunction

    typedef enum logic [1:0] {
        StLoad,
        StFull,
        StDrain,
        StSwap
    } benes_cfg_state_t;

endpackage

// File: rtl/benes_vld_pipe.sv
// Valid-bit shadow of the LAT-deep registered data path around the benes network.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   i_adv      : advance enable shared with every data-path register
//   i_in       : valid bit entering stage 0
//   o_out      : valid bit leaving the last stage
//   o_empty    : no beat anywhere in the pipe
module benes_vld_pipe #(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_adv,
    input  logic i_in,
    output logic o_out,
    output logic o_empty
);

    logic [LAT-1:0] r_vld;

    generate
        if (LAT == 1) begin : g_single
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_vld <= '0;
                end else if (i_adv) begin
                    r_vld <= i_in;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_vld <= '0;
                end else if (i_adv) begin
                    r_vld <= {r_vld[LAT-2:0], i_in};
                end
            end
        end
    endgenerate

    assign o_out   = r_vld[LAT-1];
    assign o_empty = ~|r_vld;

endmodule

// File: rtl/benes_cfg_ctrl.sv
// Configuration and flow controller for the benes permutation network.
// A new permutation is loaded stage by stage into a shadow register and only copied to the
// active control_bit once the data path is empty, so no beat sees a mixed configuration.
// Optional feature macro: BENES_CFG_PARITY_EN adds cfg_par (even parity over cfg_data).
// Ports:
//   clk, n_rst                     : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready/cfg_data   : one stage of switch bits per accepted beat
//   cfg_last                       : marks the beat for the final stage
//   cfg_par                        : even parity over cfg_data (parity build only)
//   commit/commit_done             : level swap request / one-cycle completion pulse
//   in_valid/in_ready              : data beat handshake at the network input
//   out_valid/out_ready            : data beat handshake at the network output
//   adv                            : enable for all data-path registers
//   control_bit                    : active configuration driven to benes
//   cfg_err/err_clr                : sticky protocol error and its clear
module benes_cfg_ctrl
    import benes_pkg::*;
#(
    parameter int unsigned SIZE = 32,
    parameter int unsigned LAT  = 1
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [benes_sww(SIZE)-1:0]        cfg_data,
    input  logic                              cfg_last,
`ifdef BENES_CFG_PARITY_EN
    input  logic                              cfg_par,
`endif
    input  logic                              commit,
    output logic                              commit_done,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              adv,
    output logic [benes_bitwidth(SIZE)-1:0]   control_bit,
    output logic                              cfg_err,
    input  logic                              err_clr
);

    localparam int unsigned STAGES   = benes_stages(SIZE);
    localparam int unsigned SWW      = benes_sww(SIZE);
    localparam int unsigned BITWIDTH = benes_bitwidth(SIZE);
    localparam int unsigned KW       = $clog2(STAGES + 1);

    benes_cfg_state_t    r_state, w_state_next;
    logic [KW-1:0]       r_k, w_k_next;
    logic [BITWIDTH-1:0] r_shadow, w_shadow_next;
    logic [BITWIDTH-1:0] r_ctrl, w_ctrl_next;
    logic                r_err, w_err_next, w_err_set;
    logic                w_adv, w_pipe_empty, w_in_fire;
    logic                w_at_last, w_par_bad, w_beat_bad;

    // Whole pipe stalls when the output beat is not taken.
    assign w_adv     = ~out_valid | out_ready;
    assign adv       = w_adv;
    assign in_ready  = w_adv & ((r_state == StLoad) | (r_state == StFull));
    assign w_in_fire = in_valid & in_ready;

    benes_vld_pipe #(
        .LAT (LAT)
    ) u_vld_pipe (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_adv   (w_adv),
        .i_in    (w_in_fire),
        .o_out   (out_valid),
        .o_empty (w_pipe_empty)
    );

`ifdef BENES_CFG_PARITY_EN
    assign w_par_bad = cfg_par != (^cfg_data);
`else
    assign w_par_bad = 1'b0;
`endif

    // cfg_last must appear exactly on the final stage's beat.
    assign w_at_last  = (r_k == KW'(STAGES - 1));
    assign w_beat_bad = (cfg_last != w_at_last) | w_par_bad;

    always_comb begin
        w_state_next  = r_state;
        w_k_next      = r_k;
        w_shadow_next = r_shadow;
        w_ctrl_next   = r_ctrl;
        w_err_set     = 1'b0;
        cfg_ready     = 1'b0;
        commit_done   = 1'b0;

        unique case (r_state)
            StLoad: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (w_beat_bad) begin
                        w_err_set     = 1'b1;
                        w_k_next      = '0;
                        w_shadow_next = '0;
                    end else begin
                        w_shadow_next[r_k*SWW +: SWW] = cfg_data;
                        w_k_next = r_k + KW'(1);
                        if (cfg_last) begin
                            w_state_next = StFull;
                        end
                    end
                end
            end
            StFull: begin
                if (commit) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_pipe_empty) begin
                    w_state_next = StSwap;
                end
            end
            StSwap: begin
                commit_done  = 1'b1;
                w_ctrl_next  = r_shadow;
                w_k_next     = '0;
                w_state_next = StLoad;
            end
        endcase

        // A new error outranks a simultaneous clear.
        if (w_err_set) begin
            w_err_next = 1'b1;
        end else if (err_clr) begin
            w_err_next = 1'b0;
        end else begin
            w_err_next = r_err;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= StLoad;
            r_k      <= '0;
            r_shadow <= '0;
            r_ctrl   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_k      <= w_k_next;
            r_shadow <= w_shadow_next;
            r_ctrl   <= w_ctrl_next;
            r_err    <= w_err_next;
        end
    end

    assign control_bit = r_ctrl;
    assign cfg_err     = r_err;

endmodule
